// File: rtl/pad_share_arb.sv
// -----------------------------------------------------------------------------
// pad_share_arb
//
// Shares one general-purpose I/O pad between NREQ peripheral requesters.
// A round-robin arbiter picks the next owner. The turnaround sequencer keeps
// the pad output driver off for TURN cycles before a grant and after a
// release, so the driver never passes directly from one owner to another.
// The pad input value is returned only to the current owner.
//
// Optional feature (compile-time macro):
//   PINMUX_IN_SYNC_EN  - when defined, pad_i_ival passes through a 2-flop
//                        synchronizer (2 cycles of input latency). When it is
//                        undefined, the pad input reaches ival_o
//                        combinationally.
//
// Parameters:
//   NREQ  number of requesters (2..16)
//   IDXW  owner index width, at least clog2(NREQ)
//   TURN  turnaround cycles with the driver off (0..15)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_i[NREQ]         level request per requester, held while it owns the pad
//   req_oval_i[NREQ]    per-requester output value
//   req_oe_i[NREQ]      per-requester output enable
//   cfg_ie_i            pad input enable
//   cfg_pue_i           pull-up enable
//   cfg_pde_i           pull-down enable
//   pad_i_ival          input value from the pad cell
//   gnt_o[NREQ]         registered one-hot grant
//   ival_o[NREQ]        pad input, routed only to the granted bit
//   owner_o             index of the current or most recent owner
//   busy_o              high in every state except IDLE
//   pad_o_*             registered pad cell controls (oval, oe, ie, pue, pde)
// -----------------------------------------------------------------------------
module pad_share_arb #(
   parameter int NREQ = 4,
   parameter int IDXW = 2,
   parameter int TURN = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic [NREQ-1:0] req_oval_i,
   input  logic [NREQ-1:0] req_oe_i,
   input  logic            cfg_ie_i,
   input  logic            cfg_pue_i,
   input  logic            cfg_pde_i,
   input  logic            pad_i_ival,
   output logic [NREQ-1:0] gnt_o,
   output logic [NREQ-1:0] ival_o,
   output logic [IDXW-1:0] owner_o,
   output logic            busy_o,
   output logic            pad_o_oval,
   output logic            pad_o_oe,
   output logic            pad_o_ie,
   output logic            pad_o_pue,
   output logic            pad_o_pde
);

   localparam int CNTW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      OWN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state;
   logic [CNTW-1:0] cnt;
   logic [IDXW-1:0] rr;
   logic [IDXW-1:0] win;
   logic            win_found;
   logic [IDXW-1:0] rr_cand;
   logic            ival_s;

   // Next index modulo NREQ (NREQ need not be a power of two).
   function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] idx);
      if (int'(idx) >= NREQ - 1) begin
         return '0;
      end
      return idx + IDXW'(1);
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin search: walk from rr upward, wrapping, and take the first
   // active request.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      rr_cand   = rr;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_found && req_i[rr_cand]) begin
            win_found = 1'b1;
            win       = rr_cand;
         end
         rr_cand = wrap_inc(rr_cand);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         rr         <= '0;
         owner_o    <= '0;
         gnt_o      <= '0;
         pad_o_oe   <= 1'b0;
         pad_o_oval <= 1'b0;
         pad_o_ie   <= 1'b0;
         pad_o_pue  <= 1'b0;
         pad_o_pde  <= 1'b0;
      end else begin
         // Pad configuration follows cfg_* in every state; pull-up wins.
         pad_o_ie  <= cfg_ie_i;
         pad_o_pue <= cfg_pue_i;
         pad_o_pde <= cfg_pde_i & ~cfg_pue_i;

         case (state)
            IDLE: begin
               gnt_o      <= '0;
               pad_o_oe   <= 1'b0;
               pad_o_oval <= 1'b0;
               if (win_found) begin
                  owner_o <= win;
                  if (TURN == 0) begin
                     state      <= OWN;
                     gnt_o      <= onehot(win);
                     rr         <= wrap_inc(win);
                     pad_o_oe   <= req_oe_i[win];
                     pad_o_oval <= req_oval_i[win];
                  end else begin
                     state <= SETUP;
                     cnt   <= CNTW'(TURN);
                  end
               end
            end

            SETUP: begin
               // A request withdrawn during setup aborts without a grant and
               // leaves rr untouched, so fairness is not consumed.
               if (!req_i[owner_o]) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt <= CNTW'(1)) begin
                  state      <= OWN;
                  cnt        <= '0;
                  gnt_o      <= onehot(owner_o);
                  rr         <= wrap_inc(owner_o);
                  pad_o_oe   <= req_oe_i[owner_o];
                  pad_o_oval <= req_oval_i[owner_o];
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end

            OWN: begin
               if (!req_i[owner_o]) begin
                  // Driver and grant drop on the same edge.
                  gnt_o      <= '0;
                  pad_o_oe   <= 1'b0;
                  pad_o_oval <= 1'b0;
                  if (TURN == 0) begin
                     state <= IDLE;
                  end else begin
                     state <= DRAIN;
                     cnt   <= CNTW'(TURN);
                  end
               end else begin
                  pad_o_oe   <= req_oe_i[owner_o];
                  pad_o_oval <= req_oval_i[owner_o];
               end
            end

            DRAIN: begin
               pad_o_oe   <= 1'b0;
               pad_o_oval <= 1'b0;
               if (cnt <= CNTW'(1)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNTW'(1);
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
               gnt_o <= '0;
            end
         endcase
      end
   end

   assign busy_o = (state != IDLE);

`ifdef PINMUX_IN_SYNC_EN
   logic ival_p0;
   logic ival_p1;

   // --- input synchronizer: pad_i_ival -> p0 -> p1 ---
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ival_p0 <= 1'b0;
         ival_p1 <= 1'b0;
      end else begin
         ival_p0 <= pad_i_ival;
         ival_p1 <= ival_p0;
      end
   end

   assign ival_s = ival_p1;
`else
   assign ival_s = pad_i_ival;
`endif

   assign ival_o = {NREQ{ival_s}} & gnt_o;

endmodule

// File: tb/tb_pad_share_arb.sv
module tb_pad_share_arb;

   localparam int NREQ = 4;
   localparam int IDXW = 2;
`ifdef PINMUX_IN_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [NREQ-1:0] req, req_oe, req_oval;
   logic            cfg_ie, cfg_pue, cfg_pde, pad_i;
   logic [NREQ-1:0] gnt, ival;
   logic [IDXW-1:0] owner;
   logic            busy, p_oval, p_oe, p_ie, p_pue, p_pde;

   logic [NREQ-1:0] z_req, z_oe, z_oval;
   logic [NREQ-1:0] z_gnt, z_ival;
   logic [IDXW-1:0] z_owner;
   logic            z_busy, z_poval, z_poe, z_pie, z_ppue, z_ppde;

   pad_share_arb #(.NREQ(NREQ), .IDXW(IDXW), .TURN(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .req_oval_i(req_oval), .req_oe_i(req_oe),
      .cfg_ie_i(cfg_ie), .cfg_pue_i(cfg_pue), .cfg_pde_i(cfg_pde), .pad_i_ival(pad_i),
      .gnt_o(gnt), .ival_o(ival), .owner_o(owner), .busy_o(busy),
      .pad_o_oval(p_oval), .pad_o_oe(p_oe), .pad_o_ie(p_ie), .pad_o_pue(p_pue), .pad_o_pde(p_pde)
   );

   pad_share_arb #(.NREQ(NREQ), .IDXW(IDXW), .TURN(0)) u_dut_t0 (
      .clk(clk), .rst_n(rst_n), .req_i(z_req), .req_oval_i(z_oval), .req_oe_i(z_oe),
      .cfg_ie_i(cfg_ie), .cfg_pue_i(cfg_pue), .cfg_pde_i(cfg_pde), .pad_i_ival(pad_i),
      .gnt_o(z_gnt), .ival_o(z_ival), .owner_o(z_owner), .busy_o(z_busy),
      .pad_o_oval(z_poval), .pad_o_oe(z_poe), .pad_o_ie(z_pie), .pad_o_pue(z_ppue), .pad_o_pde(z_ppde)
   );

   typedef struct packed {
      logic [3:0] req, oe, oval;
      logic [2:0] cfg;    // {ie, pue, pde}
      logic [3:0] e_gnt;
      logic [1:0] e_own;
      logic       e_busy, e_oe, e_oval;
      logic [2:0] e_pcfg; // {pad ie, pue, pde}
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   exp_order[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic [3:0] r, input logic [3:0] o, input logic [3:0] v,
                      input logic [2:0] c, input logic [3:0] g, input logic [1:0] w,
                      input logic b, input logic po, input logic pv, input logic [2:0] pc);
      vec_t t;
      t = '{req: r, oe: o, oval: v, cfg: c, e_gnt: g, e_own: w,
            e_busy: b, e_oe: po, e_oval: pv, e_pcfg: pc};
      vecs.push_back(t);
   endtask

   // Called #1 after a rising edge; reset pulse stays clear of clock edges.
   task automatic reset_dut();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t e;
      int   grants, owncnt, gap, cyc, ex;
      logic [3:0] prev_gnt;

      // Reset with every input asserted: all outputs must still be 0.
      rst_n = 1'b0;
      req = '1; req_oe = '1; req_oval = '1;
      z_req = '1; z_oe = '1; z_oval = '1;
      cfg_ie = 1'b1; cfg_pue = 1'b1; cfg_pde = 1'b1; pad_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ival", 32'(ival), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_pad", 32'({p_oval, p_oe, p_ie, p_pue, p_pde}), 32'h0);
      chk("rst_t0_gnt", 32'(z_gnt), 32'h0);

      req = '0; req_oe = '0; req_oval = '0;
      z_req = '0; z_oe = '0; z_oval = '0;
      cfg_ie = 1'b0; cfg_pue = 1'b0; cfg_pde = 1'b0; pad_i = 1'b0;
      rst_n = 1'b1;

      // Table: grant latency, release/drain, owner output following, back-to-back.
      //   req     oe      oval    cfg      gnt     own busy oe oval pcfg
      add(4'b0100, 4'b0000, 4'b0000, 3'b100, 4'b0000, 2, 1, 0, 0, 3'b100);
      add(4'b0100, 4'b0000, 4'b0000, 3'b100, 4'b0000, 2, 1, 0, 0, 3'b100);
      add(4'b0100, 4'b0100, 4'b0100, 3'b100, 4'b0100, 2, 1, 1, 1, 3'b100);
      add(4'b0100, 4'b0100, 4'b0000, 3'b100, 4'b0100, 2, 1, 1, 0, 3'b100);
      add(4'b0000, 4'b0100, 4'b0100, 3'b100, 4'b0000, 2, 1, 0, 0, 3'b100);
      add(4'b0000, 4'b0100, 4'b0100, 3'b100, 4'b0000, 2, 1, 0, 0, 3'b100);
      add(4'b0000, 4'b0100, 4'b0100, 3'b000, 4'b0000, 2, 0, 0, 0, 3'b000);
      add(4'b0000, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2, 0, 0, 0, 3'b000);
      add(4'b0110, 4'b0110, 4'b0100, 3'b111, 4'b0000, 1, 1, 0, 0, 3'b110);
      add(4'b0110, 4'b0110, 4'b0100, 3'b111, 4'b0000, 1, 1, 0, 0, 3'b110);
      add(4'b0110, 4'b0110, 4'b0110, 3'b111, 4'b0010, 1, 1, 1, 1, 3'b110);
      add(4'b0110, 4'b0110, 4'b0100, 3'b111, 4'b0010, 1, 1, 1, 0, 3'b110);
      add(4'b0110, 4'b0110, 4'b0110, 3'b111, 4'b0010, 1, 1, 1, 1, 3'b110);
      add(4'b0110, 4'b0110, 4'b0100, 3'b111, 4'b0010, 1, 1, 1, 0, 3'b110);
      add(4'b0110, 4'b0100, 4'b0110, 3'b111, 4'b0010, 1, 1, 0, 1, 3'b110);
      add(4'b0100, 4'b0110, 4'b0110, 3'b001, 4'b0000, 1, 1, 0, 0, 3'b001);
      add(4'b0100, 4'b0110, 4'b0110, 3'b001, 4'b0000, 1, 1, 0, 0, 3'b001);
      add(4'b0100, 4'b0110, 4'b0110, 3'b001, 4'b0000, 1, 0, 0, 0, 3'b001);
      add(4'b0100, 4'b0100, 4'b0000, 3'b001, 4'b0000, 2, 1, 0, 0, 3'b001);
      add(4'b0100, 4'b0100, 4'b0000, 3'b011, 4'b0000, 2, 1, 0, 0, 3'b010);
      add(4'b0100, 4'b0100, 4'b0000, 3'b011, 4'b0100, 2, 1, 1, 0, 3'b010);
      add(4'b0000, 4'b0000, 4'b0000, 3'b011, 4'b0000, 2, 1, 0, 0, 3'b010);
      add(4'b0000, 4'b0000, 4'b0000, 3'b011, 4'b0000, 2, 1, 0, 0, 3'b010);
      add(4'b0000, 4'b0000, 4'b0000, 3'b011, 4'b0000, 2, 0, 0, 0, 3'b010);

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req; req_oe = vecs[i].oe; req_oval = vecs[i].oval;
         {cfg_ie, cfg_pue, cfg_pde} = vecs[i].cfg;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(e.e_gnt));
         chk($sformatf("v%0d_owner", i), 32'(owner), 32'(e.e_own));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(e.e_busy));
         chk($sformatf("v%0d_pad_oe", i), 32'(p_oe), 32'(e.e_oe));
         chk($sformatf("v%0d_pad_oval", i), 32'(p_oval), 32'(e.e_oval));
         chk($sformatf("v%0d_pad_cfg", i), 32'({p_ie, p_pue, p_pde}), 32'(e.e_pcfg));
         chk($sformatf("v%0d_ival", i), 32'(ival), 32'h0);
      end

      // Round robin from reset: all four request, each owner keeps the pad
      // for three cycles and re-requests once released.
      reset_dut();
      exp_order = '{0, 1, 2, 3, 0};
      grants = 0; owncnt = 0; gap = 0; cyc = 0; prev_gnt = '0;
      req_oe = 4'hF; req_oval = 4'h0; req = 4'hF;
      while (grants < 5 && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("rr_oe_only_when_granted", 32'(p_oe), 32'(|gnt));
         if (gnt != 4'b0000) begin
            if (prev_gnt == 4'b0000) begin
               ex = exp_order.pop_front();
               chk($sformatf("rr_grant%0d", grants), 32'(gnt), 32'(4'b0001 << ex));
               if (grants > 0) chk("rr_idle_gap_ge5", 32'(gap >= 5), 32'h1);
               grants++;
               owncnt = 0;
            end
            owncnt++;
            gap = 0;
            if (owncnt == 3) req = req & ~gnt;
         end else begin
            gap++;
            req = 4'hF;
         end
         prev_gnt = gnt;
      end
      if (grants < 5) chk("rr_timeout_grants", 32'(grants), 32'd5);
      req = '0; req_oe = '0;
      repeat (4) @(posedge clk);
      #1;

      // Request withdrawn in SETUP: abort to IDLE, rr unchanged.
      reset_dut();
      req = 4'b0010;
      @(posedge clk); #1;
      chk("abort_setup_busy", 32'(busy), 32'h1);
      chk("abort_setup_owner", 32'(owner), 32'h1);
      req = 4'b0000;
      @(posedge clk); #1;
      chk("abort_idle_busy", 32'(busy), 32'h0);
      chk("abort_idle_gnt", 32'(gnt), 32'h0);
      req = 4'b0110;
      @(posedge clk); #1;
      chk("abort_rr_unchanged_owner", 32'(owner), 32'h1);
      @(posedge clk); #1;
      chk("abort_no_early_gnt", 32'(gnt), 32'h0);
      @(posedge clk); #1;
      chk("abort_next_gnt", 32'(gnt), 32'b0010);
      req = '0;
      repeat (4) @(posedge clk);
      #1;

      // Pull priority and input return to owner 3.
      reset_dut();
      cfg_pue = 1'b1; cfg_pde = 1'b1; cfg_ie = 1'b1;
      req = 4'b1000;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (gnt == 4'b0000 && cyc < 20);
      chk("ival_owner3_gnt", 32'(gnt), 32'b1000);
      chk("ival_owner3_owner", 32'(owner), 32'h3);
      chk("pull_up_wins", 32'({p_pue, p_pde}), 32'b10);
      chk("ival_before", 32'(ival), 32'h0);
      pad_i = 1'b1;
      #1;
      chk("ival_lat0", 32'(ival), SYNC ? 32'h0 : 32'h8);
      @(posedge clk); #1;
      chk("ival_lat1", 32'(ival), SYNC ? 32'h0 : 32'h8);
      @(posedge clk); #1;
      chk("ival_lat2", 32'(ival), 32'h8);
      req = '0;
      @(posedge clk); #1;
      chk("ival_after_release", 32'(ival), 32'h0);
      pad_i = 1'b0; cfg_pue = 1'b0; cfg_pde = 1'b0; cfg_ie = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // TURN = 0 instance: one-cycle grant, direct release, async reset.
      reset_dut();
      z_req = 4'b0001; z_oe = 4'b0001;
      #1;
      chk("t0_no_gnt_before_edge", 32'(z_gnt), 32'h0);
      @(posedge clk); #1;
      chk("t0_grant_lat", 32'(z_gnt), 32'b0001);
      chk("t0_pad_oe", 32'(z_poe), 32'h1);
      z_req = 4'b0000;
      @(posedge clk); #1;
      chk("t0_release_gnt", 32'(z_gnt), 32'h0);
      chk("t0_release_busy", 32'(z_busy), 32'h0);
      z_req = 4'b0010; z_oe = 4'b0011;
      @(posedge clk); #1;
      chk("t0_rr_gnt", 32'(z_gnt), 32'b0010);
      chk("t0_rr_oe", 32'(z_poe), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t0_async_rst_gnt", 32'(z_gnt), 32'h0);
      chk("t0_async_rst_oe", 32'(z_poe), 32'h0);
      chk("t0_async_rst_busy", 32'(z_busy), 32'h0);
      z_req = '0; z_oe = '0;
      #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
